// File: rtl/pipe_ctrl.sv
// pipe_ctrl: LC-3b five-stage sequencer, memory handshakes, load-use and branch flush.
// Define PIPE_CTRL_PERF_EN to build the stall_cycles/flush_count counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  id_src1,
  input  logic [2:0]  id_src2,
  input  logic        id_use_src1,
  input  logic        id_use_src2,
  input  logic [2:0]  ex_dest,
  input  logic        ex_load,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_indirect,
  input  logic        mem_br_taken,
  input  logic        imem_resp,
  input  logic        dmem_resp,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_write,
  output logic        dmem_addr_sel,
  output logic        ind_ptr_load,
  output logic        mdr_load,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        pcmux_sel,
  output logic        bubble_id_ex,
  output logic        flush_if_id,
  output logic        flush_ex_mem,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN, ACC1, ACC2, DONE
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_ifetch_done;
  logic   w_fetch_ok;
  logic   w_memop;
  logic   w_haz;
  logic   w_adv_ok;
  logic   w_lu;
  logic   w_adv;
  logic   w_flush;

  // reset_n gates fetch_ok so every RUN-state output is 0 in reset
  assign w_fetch_ok = reset_n & (imem_resp | r_ifetch_done);
  assign w_memop    = mem_read | mem_write;
  assign w_haz      = ex_load &
                      ((id_use_src1 & (id_src1 == ex_dest)) |
                       (id_use_src2 & (id_src2 == ex_dest)));
  assign w_adv_ok   = w_fetch_ok &
                      (((r_state == RUN) & !w_memop) |
                       (r_state == DONE));
  assign w_flush    = w_adv_ok & mem_br_taken;
  assign w_lu       = w_adv_ok & (r_state == RUN) &
                      !mem_br_taken & w_haz;
  assign w_adv      = w_adv_ok & !w_lu;

  assign imem_req     = reset_n & !r_ifetch_done;
  assign load_pc      = w_adv;
  assign load_if_id   = w_adv;
  assign load_id_ex   = w_adv_ok;
  assign load_ex_mem  = w_adv_ok;
  assign load_mem_wb  = w_adv_ok;
  assign pcmux_sel    = w_flush;
  assign flush_if_id  = w_flush;
  assign flush_ex_mem = w_flush;
  assign bubble_id_ex = w_flush | w_lu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RUN;
      r_ifetch_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_adv)
        r_ifetch_done <= 1'b0;
      else if (imem_resp)
        r_ifetch_done <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    dmem_req      = 1'b0;
    dmem_write    = 1'b0;
    dmem_addr_sel = 1'b0;
    ind_ptr_load  = 1'b0;
    mdr_load      = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_memop) w_next = ACC1;
      end
      ACC1: begin
        dmem_req   = 1'b1;
        dmem_write = mem_write & !mem_indirect;
        if (dmem_resp) begin
          if (mem_indirect) begin
            ind_ptr_load = 1'b1;
            w_next       = ACC2;
          end else begin
            mdr_load = mem_read;
            w_next   = DONE;
          end
        end
      end
      ACC2: begin
        dmem_req      = 1'b1;
        dmem_addr_sel = 1'b1;
        dmem_write    = mem_write;
        if (dmem_resp) begin
          mdr_load = mem_read;
          w_next   = DONE;
        end
      end
      DONE: begin
        if (w_fetch_ok) w_next = RUN;
      end
      default: w_next = RUN;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] r_stall;
  logic [15:0] r_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= 16'h0;
      r_flush <= 16'h0;
    end else begin
      if (!w_adv && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'h1;
      if (w_flush && r_flush != 16'hFFFF)
        r_flush <= r_flush + 16'h1;
    end
  end

  assign stall_cycles = r_stall;
  assign flush_count  = r_flush;
`else
  assign stall_cycles = 16'h0;
  assign flush_count  = 16'h0;
`endif

endmodule
